// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC, NOP word and PC step.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST           = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h4000_0000;
  localparam logic [31:0] INST_BYTES_DEFAULT = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_adder.sv
// Core 32-bit adder, used here for the sequential PC increment (wraps modulo 2^32).
module pc_fetch_stage_adder (
  input  logic [31:0] i_in0,
  input  logic [31:0] i_in1,
  output logic [31:0] o_sum
);

  assign o_sum = i_in0 + i_in1;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: owns the PC, keeps one imem read in flight and holds the
// returned instruction in a single-entry register for decode; wrong-path responses are squashed.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_drop;
  logic         r_if_valid;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_inst;

  logic         w_slot_free;
  logic         w_issue;
  logic         w_handshake;
  logic [31:0]  w_pc_seq;

  pc_fetch_stage_adder u_pc_adder (
    .i_in0 (r_req_pc),
    .i_in1 (INST_BYTES),
    .o_sum (w_pc_seq)
  );

  // A request may only go out if its response is guaranteed a free slot.
  assign w_slot_free = !r_if_valid || id_ready;
  assign w_issue     = (r_state == ST_REQ) && w_slot_free;
  assign w_handshake = w_issue && imem_req_ready;

  assign imem_req_valid = w_issue;
  assign imem_addr      = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_inst        = r_if_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      r_pc       <= word_align(redirect_pc);
      r_if_valid <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (w_handshake) begin
            r_state  <= ST_WAIT;
            r_req_pc <= r_pc;
            r_drop   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A response landing with the redirect is simply discarded; nothing is left in flight.
          if (imem_resp_valid) begin
            r_state <= ST_REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      if (r_if_valid && id_ready)
        r_if_valid <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (w_handshake) begin
            r_state  <= ST_WAIT;
            r_req_pc <= r_pc;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            r_state <= ST_REQ;
            if (r_drop) begin
              r_drop <= 1'b0;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_req_pc;
              r_if_inst  <= imem_resp_data;
              r_pc       <= w_pc_seq;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: directed scenarios push expected (pc, inst) pairs,
// a monitor pops and compares each newly presented instruction.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_lat = 0;
  int          n_accept = 0;
  logic [31:0] last_acc = 32'h0;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  pc_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] idx;
    idx = {2'b00, a[15:2]} + 16'd1;
    return {16'hAAAA, idx};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({nm, "_addr"}, imem_addr, RST_PC);
    chk({nm, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({nm, "_if_pc"}, if_pc, 32'h0);
    chk({nm, "_if_inst"}, if_inst, NOP);
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string nm, output int c);
    bit seen;
    seen = 0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_valid && if_pc == pc) begin
        seen = 1;
        c = cyc;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: pc %h not presented within 60 cycles", nm, pc);
    end
  endtask

  task automatic wait_acc(input string nm, output logic [31:0] a);
    int  n0;
    bit  seen;
    n0 = n_accept;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (n_accept != n0) begin
        seen = 1;
        break;
      end
    end
    a = last_acc;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: no request accepted within 40 cycles", nm);
    end
  endtask

  // Memory: accepts when valid&&ready, answers mem_lat cycles after the one-cycle minimum.
  initial begin : mem_model
    logic        hs;
    logic [31:0] a;
    logic [31:0] paddr;
    bit          pend;
    int          cnt;
    pend = 0;
    cnt = 0;
    paddr = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      hs = imem_req_valid && imem_req_ready;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (hs) begin
        pend = 1;
        cnt = mem_lat;
        paddr = a;
        n_accept++;
        last_acc = a;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = mem_word(paddr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: every newly presented instruction is checked against the next expected entry.
  initial begin : monitor
    bit   prev_v;
    bit   prev_c;
    exp_t e;
    prev_v = 0;
    prev_c = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n !== 1'b1) begin
        prev_v = 0;
        prev_c = 0;
      end else begin
        if (if_valid && (!prev_v || prev_c)) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_inst: got pc %h inst %h, expected nothing", if_pc, if_inst);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_inst", if_inst, e.inst);
          end
        end
        prev_v = if_valid;
        prev_c = if_valid && id_ready;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          c0;
    int          c1;
    int          n0;
    bit          quiet;
    logic [31:0] a;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset("reset");

    // Reset release, first fetches and throughput
    exp_q.push_back({32'h4000_0000, 32'hAAAA_0001});
    exp_q.push_back({32'h4000_0004, 32'hAAAA_0002});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, 32'h4000_0000);
    wait_pc(32'h4000_0000, "first_inst", c0);
    wait_pc(32'h4000_0004, "second_inst", c1);
    id_ready = 1'b0;
    chk("throughput", 32'(c1 - c0), 32'd2);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_if_pc", if_pc, 32'h4000_0004);
      chk("bp_if_inst", if_inst, 32'hAAAA_0002);
      chk("bp_no_req", 32'(imem_req_valid), 32'd0);
    end
    exp_q.push_back({32'h4000_0008, 32'hAAAA_0003});
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    chk("bp_release_req", 32'(imem_req_valid), 32'd1);
    chk("bp_release_addr", imem_addr, 32'h4000_0008);
    wait_pc(32'h4000_0008, "third_inst", c0);
    id_ready = 1'b0;

    // Redirect while a response is pending
    mem_lat = 2;
    @(negedge clk);
    id_ready = 1'b1;
    wait_acc("acc_0c", a);
    chk("acc_0c_addr", a, 32'h4000_000C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0103;
    exp_q.push_back({32'h4000_0100, 32'hAAAA_0041});
    @(negedge clk);
    redirect_valid = 1'b0;
    quiet = 1;
    n0 = n_accept;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_valid) quiet = 0;
      if (n_accept != n0) break;
    end
    chk("drop_quiet", 32'(quiet), 32'd1);
    chk("redirect_addr", last_acc, 32'h4000_0100);
    wait_pc(32'h4000_0100, "redirect_inst", c0);
    id_ready = 1'b0;

    // Redirect in the same cycle as the response
    mem_lat = 0;
    @(negedge clk);
    id_ready = 1'b1;
    wait_acc("acc_104", a);
    chk("acc_104_addr", a, 32'h4000_0104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0200;
    exp_q.push_back({32'h4000_0200, 32'hAAAA_0081});
    @(negedge clk);
    #1;
    chk("coinc_if_valid", 32'(if_valid), 32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_addr", imem_addr, 32'h4000_0200);
    redirect_valid = 1'b0;
    wait_pc(32'h4000_0200, "coinc_inst", c0);
    id_ready = 1'b0;

    // PC wrap, redirect in REQ with the slot held
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back({32'hFFFF_FFFC, 32'hAAAA_4000});
    exp_q.push_back({32'h0000_0000, 32'hAAAA_0001});
    @(negedge clk);
    #1;
    chk("wrap_if_valid", 32'(if_valid), 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    wait_pc(32'hFFFF_FFFC, "wrap_top", c0);
    wait_pc(32'h0000_0000, "wrap_zero", c1);
    id_ready = 1'b0;

    // Asynchronous reset while waiting, stale response afterwards
    mem_lat = 3;
    @(negedge clk);
    id_ready = 1'b1;
    wait_acc("acc_04", a);
    chk("acc_04_addr", a, 32'h0000_0004);
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    rst_n = 1'b1;
    exp_q.push_back({32'h4000_0000, 32'hAAAA_0001});
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (if_valid) quiet = 0;
    end
    chk("stale_ignored", 32'(quiet), 32'd1);
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_addr", imem_addr, RST_PC);
    mem_lat = 0;
    imem_req_ready = 1'b1;
    wait_pc(32'h4000_0000, "restart_inst", c0);
    id_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
